// File: rtl/clock_ratio_checker.sv
// clock_ratio_checker: receive-side monitor for a divided clock sampled as data in the
// clk_i domain. It measures the rise-to-rise period and the high time in clk_i cycles,
// declares lock after LOCK_COUNT consecutive periods equal to EXP_RATIO, and flags
// mismatches and stuck clocks.
// Build option: define CLOCK_RATIO_CHECKER_SYNC_EN to place a 2-flop synchronizer ahead
// of the sampler when div_clk_i comes from an unrelated domain. This adds 2 clk_i cycles
// to every edge-related latency and leaves the measurements unchanged.
module clock_ratio_checker #(
  parameter int EXP_RATIO  = 3,
  parameter int MAX_RATIO  = 16,
  parameter int LOCK_COUNT = 4,
  localparam int CNT_W     = $clog2(2*MAX_RATIO+1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             div_clk_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             locked_o,
  output logic             fault_o,
  output logic             stuck_o
);

  localparam int MATCH_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT+1);

  localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(2*MAX_RATIO);
  localparam logic [CNT_W-1:0]   TMO_M1_C  = CNT_W'(2*MAX_RATIO-1);
  localparam logic [CNT_W-1:0]   EXP_C     = CNT_W'(EXP_RATIO);
  localparam logic [MATCH_W-1:0] LOCK_C    = MATCH_W'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED, FAULT} state_t;

  state_t             state_q, state_d;
  logic               s0_q, s0_d, s1_q, s1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [MATCH_W-1:0] match_q, match_d, match_inc;
  logic [CNT_W-1:0]   period_q, period_d, high_q, high_d;
  logic               valid_q, valid_d, locked_q, locked_d;
  logic               fault_q, fault_d, stuck_q, stuck_d;
  logic               rise, tmo_evt;

`ifdef CLOCK_RATIO_CHECKER_SYNC_EN
  logic sync0_q, sync1_q;

  // Two-flop synchronizer for a div_clk_i from an unrelated domain.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= div_clk_i;
      sync1_q <= sync0_q;
    end
  end

  // The sampler takes its input from the synchronizer output.
  always_comb begin
    s0_d = sync1_q;
    s1_d = s0_q;
  end
`else
  // The sampler takes div_clk_i directly because it is derived from clk_i.
  always_comb begin
    s0_d = div_clk_i;
    s1_d = s0_q;
  end
`endif

  assign rise      = s0_q & ~s1_q;
  // cnt is about to reach TIMEOUT on this edge with no rising edge seen.
  assign tmo_evt   = ~rise && (cnt_q == TMO_M1_C);
  assign match_inc = match_q + 1'b1;

  // Period and high-time counters: restart on a rise, saturate at TIMEOUT, clear on clr_i.
  always_comb begin
    cnt_d  = cnt_q;
    hcnt_d = hcnt_q;
    if (clr_i) begin
      cnt_d  = '0;
      hcnt_d = '0;
    end else if (rise) begin
      cnt_d  = CNT_W'(1);
      hcnt_d = CNT_W'(1);
    end else begin
      if (cnt_q != TIMEOUT_C)
        cnt_d = cnt_q + 1'b1;
      if (s0_q && (hcnt_q != TIMEOUT_C))
        hcnt_d = hcnt_q + 1'b1;
    end
  end

  // Lock state machine and output flags. clr_i has priority over a coincident rise,
  // and a timeout cannot coincide with a rise.
  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    fault_d  = fault_q;
    stuck_d  = stuck_q;
    if (clr_i) begin
      state_d = IDLE;
      match_d = '0;
      fault_d = 1'b0;
      stuck_d = 1'b0;
    end else if (rise) begin
      if (state_q != IDLE) begin
        valid_d  = 1'b1;
        period_d = cnt_q;
        high_d   = hcnt_q;
      end
      case (state_q)
        IDLE: begin
          state_d = MEASURE;
          match_d = '0;
        end
        MEASURE: begin
          if (cnt_q == EXP_C) begin
            match_d = match_inc;
            if (match_inc == LOCK_C)
              state_d = LOCKED;
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if (cnt_q != EXP_C) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (tmo_evt) begin
      stuck_d = 1'b1;
      case (state_q)
        LOCKED: begin
          state_d = FAULT;
          fault_d = 1'b1;
        end
        FAULT: ;
        default: begin
          state_d = IDLE;
          match_d = '0;
        end
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  // State, sampler, counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      s0_q     <= 1'b0;
      s1_q     <= 1'b0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      match_q  <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      match_q  <= match_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      fault_q  <= fault_d;
      stuck_q  <= stuck_d;
    end
  end

  assign period_o = period_q;
  assign high_o   = high_q;
  assign valid_o  = valid_q;
  assign locked_o = locked_q;
  assign fault_o  = fault_q;
  assign stuck_o  = stuck_q;

endmodule
